// File: rtl/mips_run_ctrl.sv
// Execution controller between the debug unit and the MIPS core: gates the core
// clock enable for run/step and reports a saturating cycle count and stop cause.
module mips_run_ctrl #(
    parameter int BITS_SIZE = 32,
    parameter int NUM_BP    = 4,
    parameter int STEP_SIZE = 16
) (
    input  logic                                           i_clk,
    input  logic                                           i_reset,
    input  logic                                           i_cmd_valid,
    input  logic [2:0]                                     i_cmd,
    input  logic [STEP_SIZE-1:0]                           i_step_count,
    input  logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] i_bp_index,
    input  logic [BITS_SIZE-1:0]                           i_bp_addr,
    input  logic                                           i_bp_enable,
    input  logic                                           i_halt,
    input  logic [BITS_SIZE-1:0]                           i_mips_pc,
    output logic                                           o_cmd_ready,
    output logic                                           o_ctl_clk_wiz,
    output logic [BITS_SIZE-1:0]                           o_cycle_count,
    output logic [1:0]                                     o_state,
    output logic [1:0]                                     o_stop_cause,
    output logic                                           o_done
);

    localparam int BP_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_RUN    = 3'd1,
        CMD_STEP   = 3'd2,
        CMD_STOP   = 3'd3,
        CMD_CLR    = 3'd4,
        CMD_SET_BP = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_HALT = 2'd1,
        CAUSE_BP   = 2'd2,
        CAUSE_HOST = 2'd3
    } cause_t;

    state_t                 state;
    cause_t                 cause;
    cause_t                 exit_cause;
    logic [BITS_SIZE-1:0]   count;
    logic [STEP_SIZE-1:0]   remaining;
    logic                   resume;
    logic                   done;
    logic [BITS_SIZE-1:0]   bp_addr [NUM_BP];
    logic [NUM_BP-1:0]      bp_en;
    logic                   bp_match;
    logic                   bp_hit;
    logic                   clk_en;
    logic                   stop_req;

    always_comb begin
        bp_match = 1'b0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (bp_addr[i] == i_mips_pc)) begin
                bp_match = 1'b1;
            end
        end
    end

    // resume masks a breakpoint sitting on the PC we just stopped at
    assign bp_hit   = bp_match & ~resume;
    assign stop_req = i_cmd_valid && (i_cmd == CMD_STOP);

    always_comb begin
        clk_en = 1'b0;
        case (state)
            RUN:     clk_en = ~i_halt & ~bp_hit;
            STEP:    clk_en = ~i_halt & ~bp_hit & (remaining != '0);
            default: clk_en = 1'b0;
        endcase
    end

    always_comb begin
        exit_cause = CAUSE_NONE;
        if ((state == RUN) || (state == STEP)) begin
            if (i_halt) begin
                exit_cause = CAUSE_HALT;
            end else if (bp_hit) begin
                exit_cause = CAUSE_BP;
            end else if (stop_req) begin
                exit_cause = CAUSE_HOST;
            end else if ((state == STEP) && clk_en && (remaining == STEP_SIZE'(1))) begin
                exit_cause = CAUSE_HOST;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            cause     <= CAUSE_NONE;
            count     <= '0;
            remaining <= '0;
            resume    <= 1'b0;
            done      <= 1'b0;
            bp_en     <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                bp_addr[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (clk_en) begin
                resume <= 1'b0;
                if (count != '1) begin
                    count <= count + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        case (i_cmd)
                            CMD_RUN: begin
                                state  <= RUN;
                                resume <= 1'b1;
                                cause  <= CAUSE_NONE;
                            end
                            CMD_STEP: begin
                                state     <= STEP;
                                resume    <= 1'b1;
                                cause     <= CAUSE_NONE;
                                remaining <= (i_step_count == '0) ? STEP_SIZE'(1) : i_step_count;
                            end
                            CMD_CLR: begin
                                count <= '0;
                            end
                            CMD_SET_BP: begin
                                for (int unsigned i = 0; i < NUM_BP; i++) begin
                                    if (i_bp_index == BP_W'(i)) begin
                                        bp_addr[i] <= i_bp_addr;
                                        bp_en[i]   <= i_bp_enable;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RUN, STEP: begin
                    if ((state == STEP) && clk_en) begin
                        remaining <= remaining - 1'b1;
                    end
                    if (exit_cause != CAUSE_NONE) begin
                        state <= DONE;
                        cause <= exit_cause;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready   = (state == IDLE);
    assign o_ctl_clk_wiz = clk_en;
    assign o_cycle_count = count;
    assign o_state       = state;
    assign o_stop_cause  = cause;
    assign o_done        = done;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed scenarios plus randomized run/step sessions
// checked against a transaction-level model of enabled cycles and stop cause.
module tb_mips_run_ctrl;

    localparam int BW    = 32;
    localparam int NBP   = 4;
    localparam int SW    = 16;
    localparam int NEVER = 1000;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_RUN    = 3'd1,
        CMD_STEP   = 3'd2,
        CMD_STOP   = 3'd3,
        CMD_CLR    = 3'd4,
        CMD_SET_BP = 3'd5
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic [2:0]    cmd;
    logic [SW-1:0] step_count;
    logic [1:0]    bp_index;
    logic [BW-1:0] bp_addr;
    logic          bp_enable;
    logic          halt;
    logic [BW-1:0] pc;
    logic          cmd_ready;
    logic          clk_wiz;
    logic [BW-1:0] cycle_count;
    logic [1:0]    state;
    logic [1:0]    stop_cause;
    logic          done;

    logic          s_cmd_valid;
    logic [2:0]    s_cmd;
    logic          s_ready;
    logic          s_en;
    logic [3:0]    s_count;
    logic [1:0]    s_state;
    logic [1:0]    s_cause;
    logic          s_done;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] m_bp_addr [NBP];
    bit            m_bp_en   [NBP];
    longint        m_count;

    always #5 clk = ~clk;

    mips_run_ctrl #(.BITS_SIZE(BW), .NUM_BP(NBP), .STEP_SIZE(SW)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_step_count(step_count), .i_bp_index(bp_index), .i_bp_addr(bp_addr),
        .i_bp_enable(bp_enable), .i_halt(halt), .i_mips_pc(pc),
        .o_cmd_ready(cmd_ready), .o_ctl_clk_wiz(clk_wiz), .o_cycle_count(cycle_count),
        .o_state(state), .o_stop_cause(stop_cause), .o_done(done)
    );

    mips_run_ctrl #(.BITS_SIZE(4), .NUM_BP(1), .STEP_SIZE(SW)) dut_small (
        .i_clk(clk), .i_reset(rst_n), .i_cmd_valid(s_cmd_valid), .i_cmd(s_cmd),
        .i_step_count(16'd0), .i_bp_index(1'b0), .i_bp_addr(4'd0),
        .i_bp_enable(1'b0), .i_halt(1'b0), .i_mips_pc(4'd0),
        .o_cmd_ready(s_ready), .o_ctl_clk_wiz(s_en), .o_cycle_count(s_count),
        .o_state(s_state), .o_stop_cause(s_cause), .o_done(s_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cmd(input logic [2:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        next_cycle();
        cmd_valid = 1'b0;
        cmd       = CMD_NOP;
    endtask

    task automatic set_bp(input logic [1:0] idx, input logic [BW-1:0] addr, input bit en);
        bp_index  = idx;
        bp_addr   = addr;
        bp_enable = en;
        idle_cmd(CMD_SET_BP);
        m_bp_addr[idx] = addr;
        m_bp_en[idx]   = en;
    endtask

    task automatic clr_count();
        idle_cmd(CMD_CLR);
        m_count = 0;
    endtask

    task automatic s_pulse(input logic [2:0] c);
        s_cmd_valid = 1'b1;
        s_cmd       = c;
        next_cycle();
        s_cmd_valid = 1'b0;
        s_cmd       = CMD_NOP;
    endtask

    function automatic bit model_bp(input logic [BW-1:0] a);
        bit hit = 1'b0;
        for (int i = 0; i < NBP; i++) begin
            if (m_bp_en[i] && (m_bp_addr[i] == a)) hit = 1'b1;
        end
        return hit;
    endfunction

    // One RUN/STEP session. The core is modelled as advancing PC by 4 per enabled
    // cycle; halt rises once h cycles have executed, STOP is sent after s cycles.
    task automatic run_txn(input bit is_step, input int n, input int h, input int s,
                           input bit junk, input string tag);
        int            e_exp;
        int            cause_exp;
        int            jb;
        int            nn;
        int            enables;
        int            cyc;
        int            done_cyc;
        bit            stop_sent;
        bit            halt_viol;
        bit            got_done;
        logic [BW-1:0] p0;

        p0    = pc;
        nn    = (n == 0) ? 1 : n;
        jb    = -1;
        for (int k = 1; k <= 64; k++) begin
            if (model_bp(p0 + BW'(4 * k))) begin
                jb = k;
                break;
            end
        end
        e_exp     = -1;
        cause_exp = 0;
        for (int k = 0; k <= 200 && e_exp < 0; k++) begin
            if (is_step && k == nn) begin
                e_exp = k; cause_exp = 3;
            end else if (k >= h) begin
                e_exp = k; cause_exp = 1;
            end else if (k == jb) begin
                e_exp = k; cause_exp = 2;
            end else if (k == s) begin
                e_exp = k + 1; cause_exp = 3;
            end
        end

        step_count = SW'(n);
        idle_cmd(is_step ? CMD_STEP : CMD_RUN);

        enables   = 0;
        cyc       = 0;
        done_cyc  = -1;
        stop_sent = 1'b0;
        halt_viol = 1'b0;
        got_done  = 1'b0;
        while (!got_done && cyc < 300) begin
            cyc++;
            pc   = p0 + BW'(4 * enables);
            halt = (enables >= h);
            if (!stop_sent && enables == s) begin
                cmd_valid = 1'b1;
                cmd       = CMD_STOP;
                stop_sent = 1'b1;
            end else if (junk && $urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b1;
                case ($urandom_range(0, 6))
                    0:       cmd = CMD_NOP;
                    1:       cmd = CMD_RUN;
                    2:       cmd = CMD_STEP;
                    3:       cmd = CMD_CLR;
                    4:       cmd = CMD_SET_BP;
                    5:       cmd = 3'd6;
                    default: cmd = 3'd7;
                endcase
                step_count = SW'($urandom);
                bp_index   = 2'($urandom);
                bp_addr    = p0 + BW'(4 * $urandom_range(0, 8));
                bp_enable  = 1'b1;
            end else begin
                cmd_valid = 1'b0;
                cmd       = CMD_NOP;
            end
            @(negedge clk);
            if (clk_wiz) begin
                enables++;
                if (halt) halt_viol = 1'b1;
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
            next_cycle();
        end
        cmd_valid = 1'b0;
        cmd       = CMD_NOP;
        halt      = 1'b0;
        pc        = p0 + BW'(4 * enables);

        m_count = m_count + e_exp;
        if (m_count > 64'hFFFF_FFFF) m_count = 64'hFFFF_FFFF;

        check($sformatf("%s.finished", tag), got_done, 1'b1);
        check($sformatf("%s.enables", tag), enables, e_exp);
        check($sformatf("%s.done_cycle", tag), done_cyc,
              e_exp + (((cause_exp == 1) || (cause_exp == 2)) ? 2 : 1));
        check($sformatf("%s.en_during_halt", tag), halt_viol, 1'b0);
        @(negedge clk);
        check($sformatf("%s.cause", tag), stop_cause, cause_exp);
        check($sformatf("%s.count", tag), cycle_count, m_count[BW-1:0]);
        check($sformatf("%s.ready", tag), cmd_ready, 1'b1);
        check($sformatf("%s.state", tag), state, 2'd0);
        check($sformatf("%s.done_len", tag), done, 1'b0);
        next_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cnt;
        int is_step;
        int n;
        int h;
        int s;
        int r;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd         = CMD_NOP;
        step_count  = '0;
        bp_index    = '0;
        bp_addr     = '0;
        bp_enable   = 1'b0;
        halt        = 1'b0;
        pc          = '0;
        s_cmd_valid = 1'b0;
        s_cmd       = CMD_NOP;
        m_count     = 0;
        for (int i = 0; i < NBP; i++) begin
            m_bp_addr[i] = '0;
            m_bp_en[i]   = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", cmd_ready, 1'b1);
        check("rst.en", clk_wiz, 1'b0);
        check("rst.count", cycle_count, '0);
        check("rst.state", state, 2'd0);
        check("rst.cause", stop_cause, 2'd0);
        check("rst.done", done, 1'b0);
        rst_n = 1'b1;
        next_cycle();

        run_txn(1'b1, 5, NEVER, NEVER, 1'b0, "step5");
        run_txn(1'b1, 0, NEVER, NEVER, 1'b0, "step0");

        clr_count();
        set_bp(2'd2, 32'h20, 1'b1);
        pc = '0;
        run_txn(1'b0, 0, NEVER, NEVER, 1'b0, "bp_hit");
        run_txn(1'b0, 0, NEVER, 3, 1'b0, "bp_resume");
        run_txn(1'b0, 0, 2, 2, 1'b0, "halt_stop");
        run_txn(1'b0, 0, 0, NEVER, 1'b0, "halt_first");

        // narrow counter saturates; commands other than STOP are ignored while running
        s_pulse(CMD_RUN);
        s_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            s_cmd_valid = (i >= 5 && i <= 7);
            s_cmd       = (i == 5) ? CMD_CLR : (i == 6) ? CMD_STEP : CMD_RUN;
            @(negedge clk);
            if (s_en) s_cnt++;
            next_cycle();
        end
        s_cmd_valid = 1'b0;
        @(negedge clk);
        check("sat.state", s_state, 2'd1);
        check("sat.enables", s_cnt, 20);
        next_cycle();
        s_pulse(CMD_STOP);
        @(negedge clk);
        check("sat.count", s_count, 4'hF);
        check("sat.done", s_done, 1'b1);
        next_cycle();
        @(negedge clk);
        check("sat.cause", s_cause, 2'd3);
        check("sat.ready", s_ready, 1'b1);
        next_cycle();
        s_pulse(CMD_CLR);
        @(negedge clk);
        check("sat.clr", s_count, 4'h0);
        next_cycle();

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 3);
            if (r == 0) set_bp(2'($urandom), pc + BW'(4 * $urandom_range(1, 15)), 1'($urandom));
            else if (r == 1) clr_count();
            is_step = $urandom_range(0, 1);
            n       = $urandom_range(0, 12);
            h       = ($urandom_range(0, 1) == 0) ? NEVER : int'($urandom_range(0, 15));
            if (is_step != 0) s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : NEVER;
            else s = $urandom_range(0, 25);
            run_txn(is_step != 0, n, h, s, 1'b1, $sformatf("rand%0d", t));
        end

        set_bp(2'd0, 32'h1000, 1'b1);
        pc         = 32'h0F00;
        step_count = 16'd50;
        idle_cmd(CMD_STEP);
        repeat (3) next_cycle();
        rst_n = 1'b0;
        #1;
        check("arst.en", clk_wiz, 1'b0);
        check("arst.state", state, 2'd0);
        check("arst.count", cycle_count, '0);
        check("arst.ready", cmd_ready, 1'b1);
        next_cycle();
        rst_n   = 1'b1;
        m_count = 0;
        for (int i = 0; i < NBP; i++) begin
            m_bp_addr[i] = '0;
            m_bp_en[i]   = 1'b0;
        end
        next_cycle();
        pc = 32'h1000 - 32'd8;
        run_txn(1'b0, 0, NEVER, 5, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Execution controller sitting between the debug unit and the MIPS core, replacing the bare clock-enable/cycle-count register in the top level. It accepts host commands (run, step N cycles, stop, clear count, program breakpoint) and gates the core clock-enable `o_ctl_clk_wiz`. It stops on halt, on any of `NUM_BP` PC breakpoints, or on host request, and reports a saturating executed-cycle count and the stop cause back to the debug unit.

## Interface
- `BITS_SIZE`, 32, width of the PC and the cycle counter.
- `NUM_BP`, 4, number of PC breakpoint slots (≥1).
- `STEP_SIZE`, 16, width of the step count.
- `i_clk`  in  1  core clock.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_cmd_valid`  in  1  command strobe, one cycle.
- `i_cmd`  in  3  command code: 0 NOP, 1 RUN, 2 STEP, 3 STOP, 4 CLR_COUNT, 5 SET_BP.
- `i_step_count`  in  STEP_SIZE  cycles for STEP; 0 is treated as 1.
- `i_bp_index`  in  clog2(NUM_BP) (min 1)  slot for SET_BP.
- `i_bp_addr`  in  BITS_SIZE  breakpoint PC for SET_BP.
- `i_bp_enable`  in  1  enable bit written by SET_BP.
- `i_halt`  in  1  MIPS halt flag.
- `i_mips_pc`  in  BITS_SIZE  current fetch PC.
- `o_cmd_ready`  out  1  high in IDLE.
- `o_ctl_clk_wiz`  out  1  core clock enable.
- `o_cycle_count`  out  BITS_SIZE  enabled cycles since last clear, saturating.
- `o_state`  out  2  0 IDLE, 1 RUN, 2 STEP, 3 DONE.
- `o_stop_cause`  out  2  0 none, 1 halt, 2 breakpoint, 3 host/step complete.
- `o_done`  out  1  one-cycle pulse on entering DONE.

## Operation
- Reset (async, `i_reset`=0): state IDLE; count 0; remaining 0; all BP slots disabled, addr 0; `o_stop_cause` 0; all outputs 0 except `o_cmd_ready`=1.
- Commands are sampled on a rising edge when `i_cmd_valid`=1. RUN, STEP, CLR_COUNT and SET_BP act only in IDLE and are ignored elsewhere. STOP acts only in RUN or STEP. NOP and invalid codes (6, 7) are ignored.
- IDLE:
  - RUN → RUN, sets the resume flag.
  - STEP → STEP with remaining = max(`i_step_count`,1), sets the resume flag.
  - CLR_COUNT → count 0.
  - SET_BP writes the slot addr/enable next cycle.
  - RUN/STEP clear `o_stop_cause` to 0.
- `bp_hit` = OR over slots of (enable & addr==`i_mips_pc`) & ~resume.
- The resume flag clears after the first cycle with `o_ctl_clk_wiz`=1. A breakpoint at the current PC therefore does not re-trigger immediately on resume.
- `o_ctl_clk_wiz` (combinational):
  - RUN: `~i_halt & ~bp_hit`.
  - STEP: `~i_halt & ~bp_hit & remaining≠0`.
  - 0 in IDLE and DONE.
- RUN exits to DONE on: `i_halt` (cause 1), else `bp_hit` (cause 2), else STOP (cause 3). Priority is halt > bp > host when events coincide.
- STEP:
  - Each enabled cycle decrements remaining.
  - When remaining reaches 0 (the edge of the last enabled cycle) → DONE, cause 3.
  - Halt, bp and STOP exit as in RUN with the same priority.
- DONE lasts one cycle with `o_done`=1, then → IDLE. `o_stop_cause` holds until the next RUN/STEP.
- The counter increments on every edge with `o_ctl_clk_wiz`=1 and saturates at 2^BITS_SIZE−1. CLR_COUNT while saturated → 0.

## Timing
- Command at edge k → new state visible after edge k. `o_ctl_clk_wiz` can be 1 in cycle k+1.
- STEP N with no stop events: exactly N cycles of enable, DONE in the cycle after the last enabled cycle, IDLE one cycle later. Total: N+2 cycles from the command edge until `o_cmd_ready` is high again.
- Halt or bp gates the enable in the same cycle it is observed (zero latency, combinational). DONE follows at the next edge.
- STOP at edge k: enable may be high in cycle k; DONE after edge k; no enable after edge k.
- RUN issued with `i_halt` already 1: no enabled cycle, DONE next edge, cause 1.
- Async reset mid-run: enable drops immediately; the count is lost.

## Test plan
- Reset, then STEP `i_step_count`=5 with PC free-running → exactly 5 enable cycles, count=5, `o_done` one pulse, cause 3, back to IDLE after N+2=7 cycles.
- STEP with `i_step_count`=0 → 1 enable cycle, count=1.
- SET_BP slot 2 to 0x20, RUN with PC incrementing by 4 from 0 → enable low when PC=0x20, cause 2, count=8. RUN again → continues past 0x20 (resume flag), count increments.
- RUN, raise `i_halt` and STOP in the same cycle → cause 1. Enable is never high while `i_halt`=1.
- BITS_SIZE=4, RUN for 20 cycles, STOP → count=15 (saturated). CLR_COUNT → 0. RUN/STEP/CLR commands issued while in RUN → ignored.
- Assert `i_reset` low mid-STEP → enable 0 asynchronously, state IDLE, count 0, breakpoints disabled.
